// File: rtl/pipe_control_stage.sv
// Registered RV32I(+M) control decoder with a valid/ready output register
// and a load-use interlock between fetch and execute.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     fetch handshake; in_ready is combinational
//   in_instr, in_pc       instruction word and its address
//   flush                 kill the held bundle and drop this cycle's input
//   out_valid/out_ready   execute handshake for the decoded bundle
//   out_*                 registered control bundle (see decode below)
//   stall                 load-use interlock is holding fetch this cycle
module pipe_control_stage #(
    parameter int ALUOP_W  = 6,
    parameter int M_EXT    = 0,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic               out_branch,
    output logic               out_jump,
    output logic               out_mem_to_reg,
    output logic               out_mem_write,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic [2:0]         out_funct3,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [4:0]         out_rd,
    output logic               out_reg_or_imm,
    output logic               out_reg_write,
    output logic               out_illegal,
    output logic               stall
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_INV  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(16);

    typedef struct packed {
        logic               branch;
        logic               jump;
        logic               mem_to_reg;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         funct3;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               reg_or_imm;
        logic               reg_write;
        logic               illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    ctrl_t              dec;
    logic               use_rs1;
    logic               use_rs2;
    logic               use_rd;
    logic               bad;
    logic [ALUOP_W-1:0] alu;

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad     = 1'b0;
        alu     = ALU_ADD;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                use_rd         = 1'b1;
                dec.reg_or_imm = 1'b1;
            end
            OPC_JAL: begin
                use_rd   = 1'b1;
                dec.jump = 1'b1;
            end
            OPC_JALR: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                dec.jump = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.branch = 1'b1;
                unique case (funct3)
                    3'd0, 3'd1: alu = ALU_SUB;
                    3'd4, 3'd5: alu = ALU_SLT;
                    3'd6, 3'd7: alu = ALU_SLTU;
                    default:    bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
                dec.reg_or_imm = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                dec.reg_or_imm = 1'b1;
                dec.mem_write  = 1'b1;
            end
            OPC_OPIMM: begin
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
                dec.reg_or_imm = 1'b1;
                // ALU codes 0..7 line up with funct3; only shifts need bit30
                if (funct3 == 3'd5)
                    alu = in_instr[30] ? ALU_SRA : ALU_SRL;
                else
                    alu = ALUOP_W'(funct3);
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == 7'h00) begin
                    alu = ALUOP_W'(funct3);
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0)
                        alu = ALU_SUB;
                    else if (funct3 == 3'd5)
                        alu = ALU_SRA;
                    else
                        alu = ALUOP_W'(funct3);
                end else if (M_EXT != 0 && funct7 == 7'h01) begin
                    alu = ALU_MUL + ALUOP_W'(funct3);
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec         = '0;
            dec.alu_op  = ALU_INV;
            dec.illegal = 1'b1;
        end else begin
            dec.alu_op    = alu;
            dec.funct3    = funct3;
            dec.rs1       = use_rs1 ? in_instr[19:15] : 5'd0;
            dec.rs2       = use_rs2 ? in_instr[24:20] : 5'd0;
            dec.rd        = use_rd ? in_instr[11:7] : 5'd0;
            dec.reg_write = use_rd & (in_instr[11:7] != 5'd0);
        end
    end

    ctrl_t       ctrl_q, ctrl_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  load_rd_q, load_rd_d;

    logic hit_rs1;
    logic hit_rs2;
    logic accept;
    logic issue;

    // Unused sources decode to x0, so they can never match the load rd
    assign hit_rs1 = (dec.rs1 != 5'd0) && (dec.rs1 == load_rd_q);
    assign hit_rs2 = (dec.rs2 != 5'd0) && (dec.rs2 == load_rd_q);
    assign stall   = in_valid && (cnt_q != 3'd0) && (hit_rs1 || hit_rs2);

    assign in_ready = reset_n & ~flush & ~stall & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    // A bundle killed by flush never reaches execute
    assign issue    = valid_q & out_ready & ~flush;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        cnt_d     = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        load_rd_d = load_rd_q;

        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;

        if (accept) begin
            ctrl_d = dec;
            pc_d   = in_pc;
        end

        if (issue && ctrl_q.mem_to_reg && ctrl_q.rd != 5'd0) begin
            cnt_d     = 3'(LOAD_LAT);
            load_rd_d = ctrl_q.rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            load_rd_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            load_rd_q <= load_rd_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_branch     = ctrl_q.branch;
    assign out_jump       = ctrl_q.jump;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_alu_op     = ctrl_q.alu_op;
    assign out_funct3     = ctrl_q.funct3;
    assign out_rs1        = ctrl_q.rs1;
    assign out_rs2        = ctrl_q.rs2;
    assign out_rd         = ctrl_q.rd;
    assign out_reg_or_imm = ctrl_q.reg_or_imm;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_pipe_control_stage.sv
// Bench for pipe_control_stage: two instances (M_EXT=0 and 1, LOAD_LAT=2)
// driven in parallel and checked against a cycle-level reference model.
module tb_pipe_control_stage;

    localparam int LAT = 2;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       m2r;
        logic       mw;
        logic [5:0] alu;
        logic [2:0] f3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       imm;
        logic       rw;
        logic       ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic [1:0]  o_valid, o_ready, o_branch, o_jump, o_m2r, o_mw;
    logic [1:0]  o_roi, o_rw, o_ill, o_stall;
    logic [31:0] o_pc [2];
    logic [5:0]  o_alu [2];
    logic [2:0]  o_f3 [2];
    logic [4:0]  o_rs1 [2];
    logic [4:0]  o_rs2 [2];
    logic [4:0]  o_rd [2];

    int n_vec = 0;
    int n_bad = 0;

    // reference model state, one per instance
    bit          mv [2];
    logic [31:0] mpc [2];
    dec_t        md [2];
    int          mcnt [2];
    logic [4:0]  mlrd [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_control_stage #(
            .ALUOP_W (6),
            .M_EXT   (g),
            .LOAD_LAT(LAT)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .in_valid      (in_valid),
            .in_ready      (o_ready[g]),
            .in_instr      (in_instr),
            .in_pc         (in_pc),
            .flush         (flush),
            .out_valid     (o_valid[g]),
            .out_ready     (out_ready),
            .out_pc        (o_pc[g]),
            .out_branch    (o_branch[g]),
            .out_jump      (o_jump[g]),
            .out_mem_to_reg(o_m2r[g]),
            .out_mem_write (o_mw[g]),
            .out_alu_op    (o_alu[g]),
            .out_funct3    (o_f3[g]),
            .out_rs1       (o_rs1[g]),
            .out_rs2       (o_rs2[g]),
            .out_rd        (o_rd[g]),
            .out_reg_or_imm(o_roi[g]),
            .out_reg_write (o_rw[g]),
            .out_illegal   (o_ill[g]),
            .stall         (o_stall[g])
        );
    end

    // Instruction-level meaning of each encoding
    function automatic dec_t mdec(logic [31:0] i, bit mext);
        dec_t d;
        bit u1, u2, ud, bad;
        int alu;
        logic [2:0] f3;
        logic [6:0] f7;
        d = '0;
        u1 = 0; u2 = 0; ud = 0; bad = 0; alu = 0;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h37, 7'h17: begin ud = 1; d.imm = 1; end
            7'h6f: begin ud = 1; d.jump = 1; end
            7'h67: begin u1 = 1; ud = 1; d.jump = 1; end
            7'h63: begin
                u1 = 1; u2 = 1; d.branch = 1;
                if (f3 < 2) alu = 9;
                else if (f3 < 4) bad = 1;
                else if (f3 < 6) alu = 2;
                else alu = 3;
            end
            7'h03: begin u1 = 1; ud = 1; d.imm = 1; d.m2r = 1; end
            7'h23: begin u1 = 1; u2 = 1; d.imm = 1; d.mw = 1; end
            7'h13: begin
                u1 = 1; ud = 1; d.imm = 1;
                alu = (f3 == 5 && i[30]) ? 8 : int'(f3);
            end
            7'h33: begin
                u1 = 1; u2 = 1; ud = 1;
                if (f7 == 0) alu = int'(f3);
                else if (f7 == 7'h20)
                    alu = (f3 == 0) ? 9 : (f3 == 5) ? 8 : int'(f3);
                else if (f7 == 1 && mext) alu = 16 + int'(f3);
                else bad = 1;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            d = '0;
            d.ill = 1;
        end else begin
            d.alu = 6'(alu);
            d.f3  = f3;
            d.rs1 = u1 ? i[19:15] : 5'd0;
            d.rs2 = u2 ? i[24:20] : 5'd0;
            d.rd  = ud ? i[11:7] : 5'd0;
            d.rw  = ud && i[11:7] != 0;
        end
        return d;
    endfunction

    function automatic bit mstall(int k);
        dec_t d;
        d = mdec(in_instr, k == 1);
        return in_valid && mcnt[k] != 0 &&
               ((d.rs1 != 0 && d.rs1 == mlrd[k]) ||
                (d.rs2 != 0 && d.rs2 == mlrd[k]));
    endfunction

    function automatic bit mready(int k);
        return reset_n && !flush && !mstall(k) && (!mv[k] || out_ready);
    endfunction

    function automatic dec_t got(int k);
        dec_t g;
        g.branch = o_branch[k];
        g.jump   = o_jump[k];
        g.m2r    = o_m2r[k];
        g.mw     = o_mw[k];
        g.alu    = o_alu[k];
        g.f3     = o_f3[k];
        g.rs1    = o_rs1[k];
        g.rs2    = o_rs2[k];
        g.rd     = o_rd[k];
        g.imm    = o_roi[k];
        g.rw     = o_rw[k];
        g.ill    = o_ill[k];
        return g;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        int s;
        i = $urandom;
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        i[11:7]  = 5'($urandom_range(0, 7));
        s = $urandom_range(0, 11);
        case (s)
            0: i[6:0] = 7'h37;
            1: i[6:0] = 7'h17;
            2: i[6:0] = 7'h6f;
            3: i[6:0] = 7'h67;
            4: i[6:0] = 7'h63;
            5: i[6:0] = 7'h03;
            6: i[6:0] = 7'h23;
            7: i[6:0] = 7'h13;
            8, 9, 10: begin
                i[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: i[31:25] = 7'h00;
                    1: i[31:25] = 7'h20;
                    2: i[31:25] = 7'h01;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return i;
    endfunction

    // Advance one clock, stepping the model with the current inputs
    task automatic cyc();
        bit          nv [2];
        logic [31:0] npc [2];
        dec_t        nd [2];
        int          ncnt [2];
        logic [4:0]  nlrd [2];
        for (int k = 0; k < 2; k++) begin
            nv[k] = mv[k]; npc[k] = mpc[k]; nd[k] = md[k];
            ncnt[k] = (mcnt[k] > 0) ? mcnt[k] - 1 : 0;
            nlrd[k] = mlrd[k];
            if (!reset_n) begin
                nv[k] = 0; npc[k] = 0; nd[k] = '0; ncnt[k] = 0; nlrd[k] = 0;
            end else begin
                if (mv[k] && out_ready && !flush && md[k].m2r && md[k].rd != 0) begin
                    ncnt[k] = LAT;
                    nlrd[k] = md[k].rd;
                end
                if (flush) nv[k] = 0;
                else if (in_valid && mready(k)) begin
                    nv[k] = 1;
                    nd[k] = mdec(in_instr, k == 1);
                    npc[k] = in_pc;
                end else if (out_ready) nv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mv[k] = nv[k]; mpc[k] = npc[k]; md[k] = nd[k];
            mcnt[k] = ncnt[k]; mlrd[k] = nlrd[k];
        end
    endtask

    task automatic drive(bit v, logic [31:0] i, bit rdy, bit fl);
        in_valid  = v;
        in_instr  = i;
        in_pc     = $urandom;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic idle(int n);
        for (int c = 0; c < n; c++) begin
            drive(0, 32'h0, 1, 0);
            cyc();
        end
    endtask

    task automatic test_reset();
        drive(1, 32'h002081B3, 1, 0);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b0 || o_stall[k] !== 1'b0 ||
                got(k) !== dec_t'(0) || o_pc[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset k=%0d: got v=%b rdy=%b st=%b bundle=%h pc=%h want all 0",
                         k, o_valid[k], o_ready[k], o_stall[k], got(k), o_pc[k]);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        idle(3);
        drive(1, 32'h002081B3, 1, 0);
        #2;
        n_vec++;
        if (o_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got %b want 1", o_ready[0]);
        end
        cyc();
        drive(1, 32'h404182B3, 1, 0);
        #2;
        n_vec++;
        if (o_valid[0] !== 1'b1 || o_alu[0] !== 6'd0 || o_rd[0] !== 5'd3 || o_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_add: got v=%b alu=%0d rd=%0d rdy=%b want 1 0 3 1",
                     o_valid[0], o_alu[0], o_rd[0], o_ready[0]);
        end
        cyc();
        drive(0, 32'h0, 1, 0);
        #2;
        n_vec++;
        if (o_valid[0] !== 1'b1 || o_alu[0] !== 6'd9 || o_rd[0] !== 5'd5) begin
            n_bad++;
            $display("FAIL b2b_sub: got v=%b alu=%0d rd=%0d want 1 9 5",
                     o_valid[0], o_alu[0], o_rd[0]);
        end
        cyc();
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1, 32'h0000A303, 1, 0);
        cyc();
        drive(0, 32'h0, 1, 0);
        #2;
        n_vec++;
        if (o_valid[0] !== 1'b1 || o_m2r[0] !== 1'b1 || o_rd[0] !== 5'd6) begin
            n_bad++;
            $display("FAIL lw_out: got v=%b m2r=%b rd=%0d want 1 1 6",
                     o_valid[0], o_m2r[0], o_rd[0]);
        end
        cyc();
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h002303B3, 1, 0);
            #2;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (o_stall[k] !== (c < 2) || o_ready[k] !== (c == 2)) begin
                    n_bad++;
                    $display("FAIL load_use c=%0d k=%0d: got stall=%b rdy=%b want %b %b",
                             c, k, o_stall[k], o_ready[k], c < 2, c == 2);
                end
            end
            cyc();
        end
        drive(0, 32'h0, 1, 0);
        #2;
        n_vec++;
        if (o_valid[1] !== 1'b1 || o_rd[1] !== 5'd7 || o_rs1[1] !== 5'd6) begin
            n_bad++;
            $display("FAIL lu_issue: got v=%b rd=%0d rs1=%0d want 1 7 6",
                     o_valid[1], o_rd[1], o_rs1[1]);
        end
        cyc();
    endtask

    task automatic test_hold();
        idle(3);
        drive(1, 32'h4030D093, 1, 0);
        cyc();
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h123454B7, 0, 0);
            #2;
            n_vec++;
            if (o_valid[0] !== 1'b1 || o_alu[0] !== 6'd8 || o_rd[0] !== 5'd1 ||
                o_roi[0] !== 1'b1 || o_ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold c=%0d: got v=%b alu=%0d rd=%0d imm=%b rdy=%b want 1 8 1 1 0",
                         c, o_valid[0], o_alu[0], o_rd[0], o_roi[0], o_ready[0]);
            end
            cyc();
        end
        idle(1);
    endtask

    task automatic test_flush();
        idle(3);
        drive(1, 32'h00208063, 0, 0);
        cyc();
        drive(1, 32'h123454B7, 1, 1);
        #2;
        n_vec++;
        if (o_valid[0] !== 1'b1 || o_branch[0] !== 1'b1 || o_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_pre: got v=%b br=%b rdy=%b want 1 1 0",
                     o_valid[0], o_branch[0], o_ready[0]);
        end
        cyc();
        drive(0, 32'h0, 1, 0);
        #2;
        n_vec++;
        if (o_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_post: got v=%b want 00", o_valid);
        end
        cyc();
    endtask

    task automatic test_mext();
        idle(3);
        drive(1, 32'h023100B3, 1, 0);
        cyc();
        drive(0, 32'h0, 1, 0);
        #2;
        n_vec++;
        if (o_valid[0] !== 1'b1 || o_ill[0] !== 1'b1 || o_rw[0] !== 1'b0 || o_rd[0] !== 5'd0) begin
            n_bad++;
            $display("FAIL mul_m0: got v=%b ill=%b rw=%b rd=%0d want 1 1 0 0",
                     o_valid[0], o_ill[0], o_rw[0], o_rd[0]);
        end
        n_vec++;
        if (o_valid[1] !== 1'b1 || o_ill[1] !== 1'b0 || o_alu[1] !== 6'd16 ||
            o_rw[1] !== 1'b1 || o_rd[1] !== 5'd1) begin
            n_bad++;
            $display("FAIL mul_m1: got v=%b ill=%b alu=%0d rw=%b rd=%0d want 1 0 16 1 1",
                     o_valid[1], o_ill[1], o_alu[1], o_rw[1], o_rd[1]);
        end
        cyc();
    endtask

    task automatic test_random();
        dec_t g, e;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, rnd_instr(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            #2;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (o_valid[k] !== mv[k] || o_ready[k] !== mready(k) ||
                    o_stall[k] !== mstall(k)) begin
                    n_bad++;
                    $display("FAIL rnd_hs c=%0d k=%0d: got v/rdy/st=%b%b%b want %b%b%b",
                             c, k, o_valid[k], o_ready[k], o_stall[k],
                             mv[k], mready(k), mstall(k));
                end
                if (mv[k]) begin
                    g = got(k);
                    e = md[k];
                    // opcode of an illegal bundle carries no meaning
                    if (e.ill) begin
                        g.alu = 0;
                        e.alu = 0;
                    end
                    n_vec++;
                    if ({o_pc[k], g} !== {mpc[k], e}) begin
                        n_bad++;
                        $display("FAIL rnd_bundle c=%0d k=%0d: got pc=%h %h want pc=%h %h",
                                 c, k, o_pc[k], g, mpc[k], e);
                    end
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h123454B7, 0, 0);
        cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b0 || got(k) !== dec_t'(0) ||
                o_pc[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_mid k=%0d: got v=%b rdy=%b bundle=%h pc=%h want 0",
                         k, o_valid[k], o_ready[k], got(k), o_pc[k]);
            end
        end
        cyc();
        reset_n = 1'b1;
        drive(1, 32'h123454B7, 1, 0);
        #2;
        n_vec++;
        if (o_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL post_reset_ready: got %b want 11", o_ready);
        end
        cyc();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mpc[k] = 0; md[k] = '0; mcnt[k] = 0; mlrd[k] = 0;
        end
        reset_n = 1'b0;
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_back_to_back();
        test_load_use();
        test_hold();
        test_flush();
        test_mext();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
